// File: rtl/sd_pkg.sv
// Shared definitions for the signed-digit to binary conversion path.
package sd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SD_W     = 16;
  localparam int SD_CHUNK = 4;

  function automatic bit chunk_ok(input int w, input int chunk);
    return (chunk > 0) && (w >= chunk) && ((w % chunk) == 0);
  endfunction

  localparam bit SD_DEFAULTS_OK = chunk_ok(SD_W, SD_CHUNK);

endpackage

// File: rtl/sd_chunk_sub.sv
// CHUNK-bit subtractor with borrow in/out; purely combinational, zero latency, no handshake.
module sd_chunk_sub #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
  output logic [CHUNK-1:0] d,
  output logic             bout
);

  // a - b - bin spans -(2^CHUNK) .. 2^CHUNK-1, so the sign of the CHUNK+1 bit result is the borrow.
  always_comb begin
    {bout, d} = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};
  end

endmodule

// File: rtl/sd_to_bin_converter.sv
// Signed-digit (xp - xn) to two's-complement, CHUNK bits per cycle; result valid NCH+1 edges after accept.
// Accept only when idle; a stalled result holds out_z/out_ovf until out_ready, no new operand taken meanwhile.
module sd_to_bin_converter
  import sd_pkg::*;
#(
  parameter int W     = SD_W,
  parameter int CHUNK = SD_CHUNK
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_xp,
  input  logic [W-1:0] in_xn,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   out_z,
  output logic         out_ovf
);

  localparam int NCH = W / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  if (!chunk_ok(W, CHUNK)) begin : g_bad_chunk
    $error("sd_to_bin_converter: W must be a positive multiple of CHUNK");
  end

  state_t         state_q;
  logic [W-1:0]   xp_q;
  logic [W-1:0]   xn_q;
  logic [W-1:0]   res_q;
  logic [W-1:0]   res_next;
  logic           borrow_q;
  logic [CW-1:0]  cnt_q;
  logic [CHUNK-1:0] diff;
  logic           bout;

  // Operands shift right each cycle so the live chunk is always at the bottom.
  sd_chunk_sub #(.CHUNK(CHUNK)) u_sub (
    .a    (xp_q[CHUNK-1:0]),
    .b    (xn_q[CHUNK-1:0]),
    .bin  (borrow_q),
    .d    (diff),
    .bout (bout)
  );

  always_comb begin
    res_next = res_q;
    res_next[int'(cnt_q)*CHUNK +: CHUNK] = diff;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_z     <= '0;
      out_ovf   <= 1'b0;
      borrow_q  <= 1'b0;
      cnt_q     <= '0;
      xp_q      <= '0;
      xn_q      <= '0;
      res_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready <= 1'b1;
          // Gate on in_ready so the first edge out of reset never accepts unannounced.
          if (in_ready && in_valid) begin
            xp_q     <= in_xp;
            xn_q     <= in_xn;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            state_q  <= CONV;
          end
        end
        CONV: begin
          xp_q     <= xp_q >> CHUNK;
          xn_q     <= xn_q >> CHUNK;
          borrow_q <= bout;
          res_q    <= res_next;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(NCH - 1)) begin
            out_z     <= {bout, res_next};
            out_ovf   <= bout ^ res_next[W-1];
            out_valid <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_to_bin_converter.sv
// Directed bench for sd_to_bin_converter with default W=16, CHUNK=4.
module tb_sd_to_bin_converter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_xp;
  logic [15:0] in_xn;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_z;
  logic        out_ovf;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  sd_to_bin_converter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_xp     (in_xp),
    .in_xn     (in_xn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_ovf   (out_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    check({tag, "_in_ready_timeout"}, 32'(in_ready), 32'd1);
  endtask

  // Full transaction: accept, count edges to out_valid, check result, stall, release.
  task automatic convert(input string tag, input logic [15:0] xp, input logic [15:0] xn,
                         input logic [16:0] exp_z, input logic exp_ovf, input int stall);
    int n;
    wait_ready(tag);
    in_valid = 1'b1;
    in_xp    = xp;
    in_xn    = xn;
    step();
    in_valid = 1'b0;
    in_xp    = ~xp;
    in_xn    = ~xn;
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd5);
    check({tag, "_z"}, 32'(out_z), 32'(exp_z));
    check({tag, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
    for (int s = 0; s < stall; s++) begin
      step();
      check({tag, "_stall_z"}, 32'(out_z), 32'(exp_z));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] rxp, rxn;
    logic [16:0] rz;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_xp     = '0;
    in_xn     = '0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_z", 32'(out_z), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    convert("basic", 16'h0005, 16'h0003, 17'h00002, 1'b0, 0);
    convert("neg1", 16'h0000, 16'h0001, 17'h1FFFF, 1'b0, 0);
    convert("neg_msb", 16'h0000, 16'h8000, 17'h18000, 1'b0, 0);
    convert("ovf_pos", 16'hFFFF, 16'h0000, 17'h0FFFF, 1'b1, 0);
    convert("ovf_neg", 16'h0000, 16'hFFFF, 17'h10001, 1'b1, 0);
    convert("redundant0", 16'hAAAA, 16'hAAAA, 17'h00000, 1'b0, 0);
    convert("mixed", 16'h7F00, 16'h00FF, 17'h07E01, 1'b0, 1);

    // Backpressure: result held, inputs ignored while stalled.
    wait_ready("bp");
    in_valid = 1'b1;
    in_xp    = 16'h0100;
    in_xn    = 16'h0001;
    step();
    for (int i = 0; i < 4; i++) step();
    check("bp_out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      in_valid = ~in_valid;
      in_xp    = in_xp + 16'h1111;
      step();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_z", 32'(out_z), 32'h000FF);
      check("bp_hold_ovf", 32'(out_ovf), 32'd0);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);

    // Reset on the second CONV edge discards the conversion.
    in_valid = 1'b1;
    in_xp    = 16'hFFFF;
    in_xn    = 16'h0000;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    step();
    check("midrst_in_ready_back", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("midrst_no_stale", 32'(out_valid), 32'd0);
    end
    convert("after_rst", 16'h1234, 16'h0234, 17'h01000, 1'b0, 0);

    // Pseudo-random pairs with random stalls; reference is plain 17-bit subtraction.
    for (int i = 0; i < 200; i++) begin
      rxp = 16'($urandom);
      rxn = 16'($urandom);
      rz  = {1'b0, rxp} - {1'b0, rxn};
      convert("rand", rxp, rxn, rz, rz[16] ^ rz[15], int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
